// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and types for the instruction-memory loader.
//   - load_state_e   : loader FSM encoding
//   - BYTES_PER_WORD : bytes per instruction word
//   - IMEM_ADDR_W / IMEM_DEPTH : default instruction memory geometry, shared with fetch
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned IMEM_DEPTH     = 1 << IMEM_ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StChk,
    StDone
  } load_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles little-endian bytes into one instruction word.
// Ports:
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_clear           : drop any partial word and restart at byte 0
//   i_en, i_byte      : accept i_byte as the next byte of the word
//   o_word_valid      : high in the cycle the last byte of a word is accepted
//   o_word            : assembled word including the byte accepted this cycle
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_word;

  // Merge the incoming byte so the top can register the full word on the 4th byte.
  always_comb begin
    w_word = r_word;
    if (i_en) begin
      w_word[{r_cnt, 3'b000} +: 8] = i_byte;
    end
  end

  assign o_word       = w_word;
  assign o_word_valid = i_en && (r_cnt == CntW'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + 1'b1;
      r_word <= w_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte program into instruction memory and holds
// the CPU in reset until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start, i_load_len     : begin a load of i_load_len words (clamped to memory depth)
//   i_byte_in, i_byte_valid : byte stream; o_byte_ready completes the handshake
//   o_mem_we/addr/wdata     : instruction memory write port
//   o_cpu_hold              : keeps CPU/fetch in reset while high
//   o_busy, o_done, o_err   : load status (o_err only with the checksum feature)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_load_len,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W:0] MaxLen = (ADDR_W + 1)'(1) << ADDR_W;

  load_state_e       r_state, w_state_d;
  logic [ADDR_W:0]   r_len, w_len_d;
  logic [ADDR_W-1:0] r_idx, w_idx_d;
  logic              r_byte_ready, w_byte_ready_d;
  logic              r_mem_we, w_mem_we_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
  logic              r_cpu_hold, w_cpu_hold_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_err, w_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum_d;
`endif

  logic              w_xfer;
  logic              w_data_xfer;
  logic              w_start_acc;
  logic [ADDR_W:0]   w_len_clamp;
  logic              w_last;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;

  assign w_xfer      = r_byte_ready && i_byte_valid;
  assign w_data_xfer = w_xfer && (r_state == StRecv);
  // start is only honoured when no load is in flight.
  assign w_start_acc = i_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_len_clamp = (i_load_len > MaxLen) ? MaxLen : i_load_len;
  assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));

  imem_byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_start_acc),
    .i_en        (w_data_xfer),
    .i_byte      (i_byte_in),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  always_comb begin
    w_state_d      = r_state;
    w_len_d        = r_len;
    w_idx_d        = r_idx;
    w_byte_ready_d = r_byte_ready;
    w_mem_we_d     = 1'b0;
    w_mem_addr_d   = r_mem_addr;
    w_mem_wdata_d  = r_mem_wdata;
    w_cpu_hold_d   = r_cpu_hold;
    w_busy_d       = r_busy;
    w_done_d       = r_done;
    w_err_d        = r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum_d       = r_csum;
`endif
    unique case (r_state)
      StIdle, StDone: begin
        if (w_start_acc) begin
          w_len_d = w_len_clamp;
          w_idx_d = '0;
          w_err_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_d = '0;
`endif
          if (w_len_clamp == '0) begin
            w_state_d      = StDone;
            w_byte_ready_d = 1'b0;
            w_busy_d       = 1'b0;
            w_done_d       = 1'b1;
            w_cpu_hold_d   = 1'b0;
          end else begin
            w_state_d      = StRecv;
            w_byte_ready_d = 1'b1;
            w_busy_d       = 1'b1;
            w_done_d       = 1'b0;
            w_cpu_hold_d   = 1'b1;
          end
        end
      end
      StRecv: begin
        if (w_data_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_d = r_csum ^ i_byte_in;
`endif
          // Register the write on the 4th byte so mem_we lands in the WRITE cycle.
          if (w_word_valid) begin
            w_state_d      = StWrite;
            w_byte_ready_d = 1'b0;
            w_mem_we_d     = 1'b1;
            w_mem_addr_d   = r_idx;
            w_mem_wdata_d  = w_word;
          end
        end
      end
      StWrite: begin
        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_d      = StChk;
          w_byte_ready_d = 1'b1;
`else
          w_state_d      = StDone;
          w_busy_d       = 1'b0;
          w_done_d       = 1'b1;
          w_cpu_hold_d   = 1'b0;
`endif
        end else begin
          w_idx_d        = r_idx + 1'b1;
          w_state_d      = StRecv;
          w_byte_ready_d = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (w_xfer) begin
          w_state_d      = StDone;
          w_byte_ready_d = 1'b0;
          w_busy_d       = 1'b0;
          w_done_d       = 1'b1;
          w_err_d        = (i_byte_in != r_csum);
          w_cpu_hold_d   = (i_byte_in != r_csum);
        end
      end
`endif
      default: begin
        w_state_d      = StIdle;
        w_byte_ready_d = 1'b0;
        w_busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_idx        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_len        <= w_len_d;
      r_idx        <= w_idx_d;
      r_byte_ready <= w_byte_ready_d;
      r_mem_we     <= w_mem_we_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_wdata  <= w_mem_wdata_d;
      r_cpu_hold   <= w_cpu_hold_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= w_csum_d;
`endif
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are queued by the
// stimulus; a monitor pops and compares on every mem_we.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] load_len;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  logic prev_we = 1'b0;
  logic [39:0] exp_q[$];

  imem_loader dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_load_len  (load_len),
    .i_byte_in   (byte_in),
    .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_hold  (cpu_hold),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      logic [39:0] e;
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
        chk("write_data", mem_wdata, e[31:0]);
      end
      last_we_cyc = cyc;
    end
    prev_we = mem_we;
  end

  task automatic push_write(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [8:0] len);
    @(negedge clk);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    bit acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_in    = b;
        acc        = byte_ready;
      end
      guard++;
      if (!acc && guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept_timeout: got no byte_ready, expected acceptance of 0x%02h", b);
        acc = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[8*i +: 8], gaps);
    end
  endtask

  // Waits for done; returns cycles since the last write.
  task automatic wait_done(output int since_we);
    int guard = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    since_we = cyc - last_we_cyc;
  endtask

  // Program: 0x00000013, 0x00100093 little-endian; index i = byte i.
  logic [63:0] prog;
  int since;

  initial begin
    prog       = 64'h0010_0093_0000_0013;
    reset      = 1'b1;
    start      = 1'b0;
    load_len   = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values, then idle with no start.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hold", {31'd0, cpu_hold}, 32'd1);
      chk("idle_ready", {31'd0, byte_ready}, 32'd0);
      chk("idle_we", {31'd0, mem_we}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end

    // Two-word load, valid held high.
    push_write(8'd0, 32'h0000_0013);
    push_write(8'd1, 32'h0010_0093);
    do_start(9'd2);
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_hold", {31'd0, cpu_hold}, 32'd1);
    chk("load_ready", {31'd0, byte_ready}, 32'd1);
    send_bytes(prog, 8, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h90, 1'b0);
`endif
    wait_done(since);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("done_latency", since, 32'd1);
`endif
    chk("done_hold", {31'd0, cpu_hold}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_ready", {31'd0, byte_ready}, 32'd0);
    chk("done_err", {31'd0, err}, 32'd0);
    chk("writes_drained_1", exp_q.size(), 32'd0);

    // Same load with a gappy stream and a start pulse mid-load that must be ignored.
    push_write(8'd0, 32'h0000_0013);
    push_write(8'd1, 32'h0010_0093);
    do_start(9'd2);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    send_bytes(prog, 5, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    load_len   = 9'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", {31'd0, busy}, 32'd1);
    send_bytes(prog >> 40, 3, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h90, 1'b1);
`endif
    wait_done(since);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("done_latency_gappy", since, 32'd1);
`endif
    chk("gappy_hold", {31'd0, cpu_hold}, 32'd0);
    chk("writes_drained_2", exp_q.size(), 32'd0);

    // Reset after 6 bytes: only word 0 is written.
    push_write(8'd0, 32'h0000_0013);
    do_start(9'd2);
    send_bytes(prog, 6, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst_addr", {24'd0, mem_addr}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    chk("writes_drained_3", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);

    // Zero-length load from idle: done next cycle, no write.
    do_start(9'd0);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_hold", {31'd0, cpu_hold}, 32'd0);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum of 01,02,04,08 is 0x0F.
    push_write(8'd0, 32'h0804_0201);
    do_start(9'd1);
    send_bytes(64'h0F08_0402_01, 5, 1'b0);
    wait_done(since);
    chk("csum_ok_err", {31'd0, err}, 32'd0);
    chk("csum_ok_hold", {31'd0, cpu_hold}, 32'd0);
    push_write(8'd0, 32'h0804_0201);
    do_start(9'd1);
    send_bytes(64'h0E08_0402_01, 5, 1'b0);
    wait_done(since);
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    chk("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("csum_bad_done", {31'd0, done}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("writes_drained_final", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
